// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and sizing for the round-robin select arbiter.
package rr_mux_arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

endpackage : rr_mux_arbiter_pkg

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             valid_o
);

    // Scan N_REQ positions starting at the pointer; index arithmetic wraps in SEL_W bits.
    always_comb begin
        logic [SEL_W-1:0] idx;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr_i + SEL_W'(i);
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared resource; drives only the select of an external 4:1 mux.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT,
    output logic [SEL_W-1:0] SEL,
    output logic             BUSY,
    output logic             TIMEOUT
);

    localparam logic [CNT_W-1:0] ToLast = CNT_W'(TO_CYCLES - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_valid;
    logic             cnt_last;

    rr_pick u_pick (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .winner_o(pick_idx),
        .valid_o (pick_valid)
    );

    assign cnt_last = (cnt_q == ToLast);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant on any request; release on DONE or when the grant budget runs out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_valid) state_d = StGrant;
            StGrant: if (DONE || cnt_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output/bookkeeping next values; SEL is left untouched on release so the mux stays stable.
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d  = N_REQ'(1) << pick_idx;
                    sel_d  = pick_idx;
                    busy_d = 1'b1;
                    ptr_d  = pick_idx + SEL_W'(1);
                    cnt_d  = '0;
                end
            end
            StGrant: begin
                if (DONE) begin
                    // DONE takes precedence over a coincident timeout.
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end else if (cnt_last) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and bookkeeping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign GNT     = gnt_q;
    assign SEL     = sel_q;
    assign BUSY    = busy_q;
    assign TIMEOUT = timeout_q;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter; outputs sampled 1 time unit after each rising edge.
module tb_rr_mux_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic       BUSY;
    logic       TIMEOUT;

    int n_pass;
    int n_total;

    rr_mux_arbiter #(.TO_CYCLES(16)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .DONE   (DONE),
        .GNT    (GNT),
        .SEL    (SEL),
        .BUSY   (BUSY),
        .TIMEOUT(TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST  = 1'b1;
        REQ  = 4'b0000;
        DONE = 1'b0;
        tick();
        tick();
        n_total++;
        if ({GNT, SEL, BUSY, TIMEOUT} !== 8'b0000_00_0_0)
            $display("FAIL reset_state: got %b expected %b", {GNT, SEL, BUSY, TIMEOUT}, 8'b0);
        else n_pass++;
        RST = 1'b0;
        tick();
        n_total++;
        if ({GNT, BUSY} !== 5'b0000_0)
            $display("FAIL idle_no_req: got %b expected %b", {GNT, BUSY}, 5'b0);
        else n_pass++;
    endtask

    task automatic test_basic();
        REQ = 4'b1010;
        tick();
        n_total++;
        if ({GNT, SEL, BUSY, TIMEOUT} !== {4'b0010, 2'd1, 1'b1, 1'b0})
            $display("FAIL basic_first: got %b expected %b", {GNT, SEL, BUSY, TIMEOUT},
                     {4'b0010, 2'd1, 1'b1, 1'b0});
        else n_pass++;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        n_total++;
        if ({GNT, SEL, BUSY, TIMEOUT} !== {4'b0000, 2'd1, 1'b0, 1'b0})
            $display("FAIL basic_release: got %b expected %b", {GNT, SEL, BUSY, TIMEOUT},
                     {4'b0000, 2'd1, 1'b0, 1'b0});
        else n_pass++;
        tick();
        n_total++;
        if ({GNT, SEL, BUSY} !== {4'b1000, 2'd3, 1'b1})
            $display("FAIL basic_second: got %b expected %b", {GNT, SEL, BUSY},
                     {4'b1000, 2'd3, 1'b1});
        else n_pass++;
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
    endtask

    // PTR is 0 here; full requests should rotate 0,1,2,3,0.
    task automatic test_round_robin();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if ({GNT, SEL, BUSY} !== {4'b0001 << order[k], order[k], 1'b1})
                $display("FAIL rr_grant_%0d: got %b expected %b", k, {GNT, SEL, BUSY},
                         {4'b0001 << order[k], order[k], 1'b1});
            else n_pass++;
            tick();
            DONE = 1'b1;
            tick();
            DONE = 1'b0;
            n_total++;
            if ({GNT, BUSY} !== 5'b0000_0)
                $display("FAIL rr_idle_%0d: got %b expected %b", k, {GNT, BUSY}, 5'b0);
            else n_pass++;
        end
        REQ = 4'b0000;
        tick();
    endtask

    // PTR is 1 here; requester 2 times out, then PTR must point at 3.
    task automatic test_timeout();
        bit held_ok;
        REQ = 4'b0100;
        tick();
        REQ = 4'b0000;
        held_ok = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (GNT !== 4'b0100 || TIMEOUT !== 1'b0 || BUSY !== 1'b1) held_ok = 1'b0;
        end
        n_total++;
        if (held_ok !== 1'b1) $display("FAIL to_hold: got %b expected %b", held_ok, 1'b1);
        else n_pass++;
        REQ = 4'b1111;
        tick();
        n_total++;
        if ({GNT, SEL, BUSY, TIMEOUT} !== {4'b0000, 2'd2, 1'b0, 1'b1})
            $display("FAIL to_pulse: got %b expected %b", {GNT, SEL, BUSY, TIMEOUT},
                     {4'b0000, 2'd2, 1'b0, 1'b1});
        else n_pass++;
        tick();
        n_total++;
        if ({GNT, SEL, TIMEOUT} !== {4'b1000, 2'd3, 1'b0})
            $display("FAIL to_ptr_next: got %b expected %b", {GNT, SEL, TIMEOUT},
                     {4'b1000, 2'd3, 1'b0});
        else n_pass++;
    endtask

    // Continues the grant to 3 from test_timeout; DONE lands on the would-be timeout edge.
    task automatic test_done_at_timeout();
        REQ = 4'b0000;
        for (int k = 1; k < 16; k++) tick();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        n_total++;
        if ({GNT, BUSY, TIMEOUT} !== 6'b0000_0_0)
            $display("FAIL done_wins: got %b expected %b", {GNT, BUSY, TIMEOUT}, 6'b0);
        else n_pass++;
        tick();
        n_total++;
        if (TIMEOUT !== 1'b0) $display("FAIL done_wins_late: got %b expected %b", TIMEOUT, 1'b0);
        else n_pass++;
    endtask

    // PTR is 0; grant 3, reset asynchronously mid-grant.
    task automatic test_reset_mid_grant();
        REQ = 4'b1000;
        tick();
        n_total++;
        if ({GNT, SEL} !== {4'b1000, 2'd3})
            $display("FAIL rst_pre: got %b expected %b", {GNT, SEL}, {4'b1000, 2'd3});
        else n_pass++;
        #2 RST = 1'b1;
        #1;
        n_total++;
        if ({GNT, SEL, BUSY, TIMEOUT} !== 8'b0)
            $display("FAIL rst_async: got %b expected %b", {GNT, SEL, BUSY, TIMEOUT}, 8'b0);
        else n_pass++;
        REQ = 4'b1001;
        tick();
        RST = 1'b0;
        tick();
        n_total++;
        if ({GNT, SEL, BUSY, TIMEOUT} !== {4'b0001, 2'd0, 1'b1, 1'b0})
            $display("FAIL rst_after: got %b expected %b", {GNT, SEL, BUSY, TIMEOUT},
                     {4'b0001, 2'd0, 1'b1, 1'b0});
        else n_pass++;
        REQ  = 4'b0000;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
    endtask

    // PTR is 1; grantee drops REQ, grant holds; DONE in IDLE changes nothing.
    task automatic test_drop_and_idle_done();
        bit held_ok;
        REQ = 4'b0010;
        tick();
        REQ = 4'b0000;
        held_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (GNT !== 4'b0010 || BUSY !== 1'b1) held_ok = 1'b0;
        end
        n_total++;
        if (held_ok !== 1'b1) $display("FAIL drop_hold: got %b expected %b", held_ok, 1'b1);
        else n_pass++;
        DONE = 1'b1;
        tick();
        tick();
        tick();
        DONE = 1'b0;
        n_total++;
        if ({GNT, SEL, BUSY, TIMEOUT} !== {4'b0000, 2'd1, 1'b0, 1'b0})
            $display("FAIL idle_done: got %b expected %b", {GNT, SEL, BUSY, TIMEOUT},
                     {4'b0000, 2'd1, 1'b0, 1'b0});
        else n_pass++;
        // PTR should be 2 now: full requests pick 2.
        REQ = 4'b1111;
        tick();
        n_total++;
        if ({GNT, SEL} !== {4'b0100, 2'd2})
            $display("FAIL ptr_after_drop: got %b expected %b", {GNT, SEL}, {4'b0100, 2'd2});
        else n_pass++;
        REQ = 4'b0000;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid_grant();
        test_drop_and_idle_done();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rr_mux_arbiter

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 16, grant-timeout limit in clock cycles (legal 2..255).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port REQ  input  4  request per requester; bit i = requester i.
REQ-005 SHALL have port DONE  input  1  single-cycle pulse from the shared resource ending the current transaction.
REQ-006 SHALL have port GNT  output  4  one-hot grant; all-zero when no grant.
REQ-007 SHALL have port SEL  output  2  index of current/last grantee; drives the select of the 4:1 32-bit datapath mux.
REQ-008 SHALL have port BUSY  output  1  high while a grant is active.
REQ-009 SHALL have port TIMEOUT  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 SHALL implement FSM with states IDLE and GRANT; all outputs registered.
REQ-011 IDLE: if any REQ bit high, SHALL pick a winner and enter GRANT; GNT/SEL/BUSY valid the next cycle (1-cycle REQ-to-GNT latency).
REQ-012 Winner SHALL be the first set REQ bit searching upward from priority pointer PTR, wrapping 3->0.
REQ-013 On each grant PTR SHALL become (winner+1) mod 4 (2-bit wrap-around).
REQ-014 GRANT: GNT SHALL stay one-hot and constant until DONE or timeout; deassertion of the grantee's REQ is ignored.
REQ-015 DONE in GRANT SHALL return FSM to IDLE; GNT=0, BUSY=0 the next cycle; exactly one IDLE cycle occurs between consecutive grants.
REQ-016 DONE in IDLE SHALL be ignored.
REQ-017 8-bit counter SHALL clear on grant and increment each GRANT cycle; when it reaches TO_CYCLES-1 without DONE, FSM SHALL return to IDLE and TIMEOUT SHALL pulse high for exactly one cycle coincident with GNT going 0.
REQ-018 DONE and timeout in the same cycle: DONE wins, TIMEOUT stays 0.
REQ-019 Timed-out requester SHALL NOT receive preference; PTR already advanced past it per REQ-013.
REQ-020 SEL SHALL hold the last granted index while IDLE (mux stays stable).
REQ-021 REQ all-zero in IDLE: FSM SHALL remain IDLE, outputs unchanged.

Reset
REQ-022 RST high SHALL immediately force state IDLE, PTR=0, counter=0, GNT=0, SEL=0, BUSY=0, TIMEOUT=0.
REQ-023 RST asserted mid-GRANT SHALL drop the grant without TIMEOUT pulse; first grant after release uses PTR=0.

Structure
REQ-024 Shared package SHALL hold the FSM state type, N_REQ=4, SEL_W=2 and counter width 8.
REQ-025 Round-robin search SHALL be a combinational sub-module rr_pick (inputs REQ, PTR; outputs winner index, valid).
REQ-026 Block SHALL contain no datapath; it only drives SEL of the external 4:1 mux.

Verification
REQ-027 After reset, REQ=4'b1010 -> cycle+1 GNT=4'b0010, SEL=1, BUSY=1; DONE -> GNT=0; next grant GNT=4'b1000, SEL=3.
REQ-028 REQ=4'b1111 held, DONE every 3rd cycle -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-029 Grant to requester 2, no DONE, TO_CYCLES=16 -> TIMEOUT pulse exactly 16 cycles after GNT rise, GNT=0 same cycle, PTR=3.
REQ-030 DONE on the final timeout cycle -> TIMEOUT=0, normal release.
REQ-031 RST pulse during GRANT to requester 3 -> GNT=0, SEL=0 immediately; with REQ=4'b1001 after release, GNT=4'b0001.
REQ-032 Grantee drops REQ mid-grant, DONE in IDLE -> grant held until DONE; IDLE DONE causes no state change.
